// File: rtl/frame_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : frame_mem_arbiter                                               |
// | Purpose  : Shares the single-port frame-buffer BRAM between three          |
// |            requesters. Port 0 (display scan-out) has fixed priority,       |
// |            ports 1 (UART loader) and 2 (image engine) are round-robined,   |
// |            and a per-port wait counter lets a starved port 1/2 request     |
// |            override the display. At most one access is issued per cycle.   |
// | Ports    : clk, rst          clock, synchronous active-high reset          |
// |            req_i/we_i       per-port request / write enable (3 bits)       |
// |            addr_i/wdata_i   per-port address / write data, port k at       |
// |                             slice [k*W +: W]                               |
// |            gnt_o            one-hot grant, combinational in cycle N        |
// |            rvalid_o/rdata_o read return in cycle N+2, shared data bus      |
// |            err_o            out-of-range access pulse in cycle N+1         |
// |            mem_*            BRAM pins, registered in cycle N+1             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module frame_mem_arbiter #(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 24,
   parameter int DEPTH        = 196608,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req_i,
   input  logic [2:0]            we_i,
   input  logic [3*ADDR_W-1:0]   addr_i,
   input  logic [3*DATA_W-1:0]   wdata_i,
   output logic [2:0]            gnt_o,
   output logic [2:0]            rvalid_o,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  err_o,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_din,
   input  logic [DATA_W-1:0]     mem_dout
);

   // One extra bit so that DEPTH == 2**ADDR_W is still representable.
   localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);
   localparam logic [7:0]      c_starve = 8'(STARVE_LIMIT);

   // -------------------------------------------------------------------------
   // Per-port views of the flattened address / data buses
   // -------------------------------------------------------------------------
   logic [ADDR_W-1:0] w_addr  [3];
   logic [DATA_W-1:0] w_wdata [3];

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_unpack
         assign w_addr[g]  = addr_i[g*ADDR_W +: ADDR_W];
         assign w_wdata[g] = wdata_i[g*DATA_W +: DATA_W];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Arbitration state
   // -------------------------------------------------------------------------
   logic [7:0] wait1_q, wait1_d;
   logic [7:0] wait2_q, wait2_d;
   // Round-robin pointer between ports 1 and 2: 0 favours port 1, 1 favours
   // port 2. Reset leaves port 1 favoured.
   logic       rr_p2_q, rr_p2_d;

   logic       w_starve1;
   logic       w_starve2;
   logic [2:0] w_gnt;
   logic       w_gnt_any;

   assign w_starve1 = req_i[1] && (wait1_q >= c_starve);
   assign w_starve2 = req_i[2] && (wait2_q >= c_starve);

   // Priority: starved port 1/2 first, then display, then the rr-favoured
   // port of 1/2. No grant is ever issued while reset is held.
   always_comb begin
      w_gnt = 3'b000;
      if (!rst) begin
         if (w_starve1 && w_starve2) begin
            w_gnt = rr_p2_q ? 3'b100 : 3'b010;
         end else if (w_starve1) begin
            w_gnt = 3'b010;
         end else if (w_starve2) begin
            w_gnt = 3'b100;
         end else if (req_i[0]) begin
            w_gnt = 3'b001;
         end else if (req_i[1] && req_i[2]) begin
            w_gnt = rr_p2_q ? 3'b100 : 3'b010;
         end else if (req_i[1]) begin
            w_gnt = 3'b010;
         end else if (req_i[2]) begin
            w_gnt = 3'b100;
         end
      end
   end

   assign w_gnt_any = |w_gnt;
   assign gnt_o     = w_gnt;

   // -------------------------------------------------------------------------
   // Granted-port access mux
   // -------------------------------------------------------------------------
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_oor;

   always_comb begin
      w_sel_we    = we_i[0];
      w_sel_addr  = w_addr[0];
      w_sel_wdata = w_wdata[0];
      if (w_gnt[1]) begin
         w_sel_we    = we_i[1];
         w_sel_addr  = w_addr[1];
         w_sel_wdata = w_wdata[1];
      end else if (w_gnt[2]) begin
         w_sel_we    = we_i[2];
         w_sel_addr  = w_addr[2];
         w_sel_wdata = w_wdata[2];
      end
   end

   assign w_oor = ({1'b0, w_sel_addr} >= c_depth);

   // -------------------------------------------------------------------------
   // Wait counters and round-robin pointer next state
   // -------------------------------------------------------------------------
   // A waiting port counts up to the limit and holds there; a grant or a
   // dropped request clears the count.
   always_comb begin
      wait1_d = 8'd0;
      wait2_d = 8'd0;
      rr_p2_d = rr_p2_q;

      if (req_i[1] && !w_gnt[1]) begin
         wait1_d = (wait1_q >= c_starve) ? c_starve : wait1_q + 8'd1;
      end
      if (req_i[2] && !w_gnt[2]) begin
         wait2_d = (wait2_q >= c_starve) ? c_starve : wait2_q + 8'd1;
      end

      // Port-0 grants leave the pointer untouched.
      if (w_gnt[1]) begin
         rr_p2_d = 1'b1;
      end else if (w_gnt[2]) begin
         rr_p2_d = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Memory stage (cycle N+1) and read-return stage (cycle N+2)
   // -------------------------------------------------------------------------
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;
   logic              err_q;
   // Stage-1 read tag: one-hot port of a read issued to the BRAM (or
   // suppressed because out of range) in the current cycle.
   logic [2:0]        s1_rd_oh_q;
   logic              s1_oor_q;
   // Stage-2 tag: aligned with mem_dout.
   logic [2:0]        s2_rvalid_q;
   logic              s2_oor_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait1_q     <= 8'd0;
         wait2_q     <= 8'd0;
         rr_p2_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         err_q       <= 1'b0;
         s1_rd_oh_q  <= 3'b000;
         s1_oor_q    <= 1'b0;
         s2_rvalid_q <= 3'b000;
         s2_oor_q    <= 1'b0;
      end else begin
         wait1_q  <= wait1_d;
         wait2_q  <= wait2_d;
         rr_p2_q  <= rr_p2_d;

         // Out-of-range accesses are granted but never reach the BRAM.
         mem_en_q <= w_gnt_any && !w_oor;
         mem_we_q <= w_gnt_any && !w_oor && w_sel_we;
         if (w_gnt_any) begin
            mem_addr_q <= w_sel_addr;
            mem_din_q  <= w_sel_wdata;
         end
         err_q <= w_gnt_any && w_oor;

         s1_rd_oh_q  <= w_sel_we ? 3'b000 : w_gnt;
         s1_oor_q    <= w_oor;
         s2_rvalid_q <= s1_rd_oh_q;
         s2_oor_q    <= s1_oor_q;
      end
   end

   assign mem_en   = mem_en_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign err_o    = err_q;
   assign rvalid_o = s2_rvalid_q;

   // The data bus is zero unless a read returns, and an out-of-range read
   // returns zero rather than whatever the BRAM last produced.
   assign rdata_o = ((|s2_rvalid_q) && !s2_oor_q) ? mem_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_frame_mem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_frame_mem_arbiter                                            |
// | Purpose  : Self-checking bench for frame_mem_arbiter: a table of single-   |
// |            cycle arbitration vectors, directed multi-cycle sequences and a |
// |            randomized run checked against a behavioural reference model.  |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_frame_mem_arbiter;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 24;
   localparam int DEPTH  = 196608;
   localparam int LIMIT  = 15;

   logic                clk = 1'b0;
   logic                rst;
   logic [2:0]          req;
   logic [2:0]          we;
   logic [3*ADDR_W-1:0] addr;
   logic [3*DATA_W-1:0] wdata;
   logic [2:0]          gnt;
   logic [2:0]          rvalid;
   logic [DATA_W-1:0]   rdata;
   logic                err;
   logic                mem_en;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_din;
   logic [DATA_W-1:0]   mem_dout;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   frame_mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .gnt_o    (gnt),
      .rvalid_o (rvalid),
      .rdata_o  (rdata),
      .err_o    (err),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   // -------------------------------------------------------------------------
   // BRAM model: 1-cycle read latency, read-first, unwritten words hold a
   // deterministic pattern so reads return distinguishable data.
   // -------------------------------------------------------------------------
   bit [DATA_W-1:0] mem_arr [DEPTH];
   bit              written [DEPTH];

   function automatic logic [DATA_W-1:0] pat(input int a);
      return 24'((a * 40503) ^ 32'h005A5A5A);
   endfunction

   always @(posedge clk) begin
      if (mem_en && (int'(mem_addr) < DEPTH)) begin
         if (mem_we) begin
            mem_arr[mem_addr] <= mem_din;
            written[mem_addr] <= 1'b1;
         end
         mem_dout <= written[mem_addr] ? mem_arr[mem_addr] : pat(int'(mem_addr));
      end
   end

   // Expected memory contents as seen by the bench.
   logic [DATA_W-1:0] shadow [int];

   function automatic logic [DATA_W-1:0] model_read(input int a);
      return shadow.exists(a) ? shadow[a] : pat(a);
   endfunction

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input bit r, input bit w, input int a,
                           input logic [DATA_W-1:0] d);
      req[p] = r;
      we[p]  = w;
      addr[p*ADDR_W +: ADDR_W]  = ADDR_W'(a);
      wdata[p*DATA_W +: DATA_W] = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the caller 1 ns into the first cycle after reset.
   task automatic do_reset();
      rst   = 1'b1;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One isolated access on port p; checks grant, memory stage and return.
   task automatic single(input int p, input bit w, input int a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
      bit oor;
      oor = (a >= DEPTH);
      set_port(p, 1'b1, w, a, d);
      @(negedge clk);
      chk("single_gnt", 32'(gnt), 1 << p);
      next_cycle();
      set_port(p, 1'b0, 1'b0, 0, 24'h0);
      @(negedge clk);
      chk("single_mem_en", 32'(mem_en), 32'(!oor));
      chk("single_mem_we", 32'(mem_we), 32'(w && !oor));
      chk("single_err", 32'(err), 32'(oor));
      if (!oor) chk("single_mem_addr", 32'(mem_addr), a);
      if (w && !oor) chk("single_mem_din", 32'(mem_din), 32'(d));
      next_cycle();
      @(negedge clk);
      chk("single_rvalid", 32'(rvalid), w ? 0 : (1 << p));
      chk("single_rdata", 32'(rdata), w ? 32'h0 : 32'(exp_rd));
      next_cycle();
      if (w && !oor) shadow[a] = d;
   endtask

   // -------------------------------------------------------------------------
   // Single-cycle arbitration vectors, each applied from reset
   // -------------------------------------------------------------------------
   typedef struct {
      logic [2:0]        req;
      logic [2:0]        we;
      int                a;
      logic [DATA_W-1:0] d;
      logic [2:0]        gnt;
      bit                en;
      bit                w;
      bit                err;
   } vec_t;

   vec_t vt[12];

   // -------------------------------------------------------------------------
   // Randomized run: requesters and reference model
   // -------------------------------------------------------------------------
   typedef struct {
      bit                v;
      int                p;
      bit                w;
      int                a;
      logic [DATA_W-1:0] d;
      bit                oor;
   } rec_t;

   bit                act [3];
   bit                rw  [3];
   int                ra  [3];
   logic [DATA_W-1:0] rd  [3];
   int                m_wait [3];
   int                m_rr;

   function automatic int model_pick();
      bit s1, s2;
      s1 = act[1] && (m_wait[1] == LIMIT);
      s2 = act[2] && (m_wait[2] == LIMIT);
      if (s1 && s2) return m_rr;
      if (s1) return 1;
      if (s2) return 2;
      if (act[0]) return 0;
      if (act[1] && act[2]) return m_rr;
      if (act[1]) return 1;
      if (act[2]) return 2;
      return -1;
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vt[0]  = '{3'b000, 3'b000, 0,      24'h000000, 3'b000, 0, 0, 0};
      vt[1]  = '{3'b001, 3'b000, 5,      24'h000000, 3'b001, 1, 0, 0};
      vt[2]  = '{3'b010, 3'b010, 32,     24'h111111, 3'b010, 1, 1, 0};
      vt[3]  = '{3'b110, 3'b000, 7,      24'h000000, 3'b010, 1, 0, 0};
      vt[4]  = '{3'b111, 3'b110, 9,      24'h333333, 3'b001, 1, 0, 0};
      vt[5]  = '{3'b100, 3'b000, 196608, 24'h000000, 3'b100, 0, 0, 1};
      vt[6]  = '{3'b010, 3'b010, 196607, 24'h123456, 3'b010, 1, 1, 0};
      vt[7]  = '{3'b010, 3'b010, 196608, 24'hFFFFFF, 3'b010, 0, 0, 1};
      vt[8]  = '{3'b101, 3'b001, 3,      24'h0ABCDE, 3'b001, 1, 1, 0};
      vt[9]  = '{3'b100, 3'b100, 262143, 24'h444444, 3'b100, 0, 0, 1};
      vt[10] = '{3'b100, 3'b100, 48,     24'h222222, 3'b100, 1, 1, 0};
      vt[11] = '{3'b011, 3'b000, 1,      24'h000000, 3'b001, 1, 0, 0};

      // ---- reset state ------------------------------------------------------
      do_reset();
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      next_cycle();

      // ---- table vectors ----------------------------------------------------
      for (int i = 0; i < 12; i++) begin
         do_reset();
         for (int p = 0; p < 3; p++) set_port(p, vt[i].req[p], vt[i].we[p], vt[i].a, vt[i].d);
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
         next_cycle();
         req = '0;
         @(negedge clk);
         chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vt[i].en));
         chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vt[i].w));
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
         if (vt[i].en) chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), vt[i].a);
         if (vt[i].w) begin
            chk($sformatf("vec%0d_mem_din", i), 32'(mem_din), 32'(vt[i].d));
            shadow[vt[i].a] = vt[i].d;
         end
         next_cycle();
      end

      // ---- single read with known contents ----------------------------------
      do_reset();
      single(1, 1'b1, 16, 24'hA5B6C7, 24'h0);
      single(2, 1'b0, 16, 24'h0, 24'hA5B6C7);

      // ---- boundary addresses -------------------------------------------------
      single(1, 1'b1, 196607, 24'h123456, 24'h0);
      single(1, 1'b1, 196608, 24'hFFFFFF, 24'h0);
      single(1, 1'b0, 196607, 24'h0, 24'h123456);
      single(1, 1'b0, 196608, 24'h0, 24'h0);

      // ---- contention: 0,1,2 then 1/2 alternation ---------------------------
      do_reset();
      set_port(0, 1'b1, 1'b0, 1, 24'h0);
      set_port(1, 1'b1, 1'b0, 2, 24'h0);
      set_port(2, 1'b1, 1'b0, 3, 24'h0);
      @(negedge clk); chk("cont_g0", 32'(gnt), 32'h1);
      next_cycle(); req[0] = 1'b0;
      @(negedge clk); chk("cont_g1", 32'(gnt), 32'h2);
      next_cycle(); req[1] = 1'b0;
      @(negedge clk); chk("cont_g2", 32'(gnt), 32'h4);
      next_cycle(); req[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("alt%0d_gnt", i), 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h4);
         next_cycle();
      end
      req = '0;
      repeat (3) next_cycle();

      // ---- starvation guard -------------------------------------------------
      do_reset();
      set_port(0, 1'b1, 1'b0, 4, 24'h0);
      set_port(1, 1'b1, 1'b0, 5, 24'h0);
      for (int c = 0; c <= LIMIT + 1; c++) begin
         @(negedge clk);
         chk($sformatf("starve_c%0d_gnt", c), 32'(gnt), (c == LIMIT) ? 32'h2 : 32'h1);
         next_cycle();
      end
      req = '0;
      repeat (3) next_cycle();

      // ---- back-to-back display reads ---------------------------------------
      do_reset();
      for (int i = 0; i < 11; i++) begin
         if (i < 8) set_port(0, 1'b1, 1'b0, i, 24'h0);
         else req = '0;
         @(negedge clk);
         if (i < 8) chk($sformatf("b2b%0d_gnt", i), 32'(gnt), 32'h1);
         if (i >= 2 && i < 10) begin
            chk($sformatf("b2b%0d_rvalid", i), 32'(rvalid), 32'h1);
            chk($sformatf("b2b%0d_rdata", i), 32'(rdata), 32'(model_read(i - 2)));
         end else begin
            chk($sformatf("b2b%0d_rvalid_idle", i), 32'(rvalid), 0);
         end
         next_cycle();
      end

      // ---- reset during a read in flight ------------------------------------
      do_reset();
      single(1, 1'b0, 4, 24'h0, model_read(4));
      set_port(0, 1'b1, 1'b0, 5, 24'h0);
      @(negedge clk); chk("rstmid_gnt", 32'(gnt), 32'h1);
      next_cycle();
      req = '0;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_rvalid", 32'(rvalid), 0);
      chk("rstmid_rdata", 32'(rdata), 0);
      chk("rstmid_gnt0", 32'(gnt), 0);
      chk("rstmid_mem_en", 32'(mem_en), 0);
      chk("rstmid_mem_we", 32'(mem_we), 0);
      chk("rstmid_err", 32'(err), 0);
      chk("rstmid_mem_addr", 32'(mem_addr), 0);
      next_cycle();
      set_port(1, 1'b1, 1'b0, 6, 24'h0);
      set_port(2, 1'b1, 1'b0, 7, 24'h0);
      @(negedge clk); chk("rstmid_rr", 32'(gnt), 32'h2);
      next_cycle();
      req = '0;
      repeat (3) next_cycle();

      // ---- randomized run against the reference model -----------------------
      begin
         rec_t h1, h2, cur;
         int   pick;
         int   last_pick;
         int   prob0;
         do_reset();
         h1 = '{0, 0, 0, 0, 24'h0, 0};
         h2 = h1;
         last_pick = -1;
         m_rr = 1;
         for (int p = 0; p < 3; p++) begin
            act[p] = 0; rw[p] = 0; ra[p] = 0; rd[p] = 24'h0; m_wait[p] = 0;
         end
         for (int cyc = 0; cyc < 3000; cyc++) begin
            prob0 = ((cyc / 500) % 2 == 1) ? 95 : 30;
            for (int p = 0; p < 3; p++) begin
               if (act[p] && last_pick == p) act[p] = 0;
               if (act[p] && $urandom_range(31) == 0) begin
                  act[p] = 0;
               end else if (!act[p] && $urandom_range(99) < ((p == 0) ? prob0 : 50)) begin
                  act[p] = 1;
                  rw[p]  = ($urandom_range(2) == 0);
                  ra[p]  = ($urandom_range(15) == 0) ? DEPTH + int'($urandom_range(65535))
                                                     : int'($urandom_range(255));
                  rd[p]  = 24'($urandom);
               end
               set_port(p, act[p], rw[p], ra[p], rd[p]);
            end
            @(negedge clk);
            pick = model_pick();
            chk("rnd_gnt", 32'(gnt), (pick >= 0) ? (1 << pick) : 0);
            chk("rnd_mem_en", 32'(mem_en), 32'(h1.v && !h1.oor));
            chk("rnd_mem_we", 32'(mem_we), 32'(h1.v && !h1.oor && h1.w));
            chk("rnd_err", 32'(err), 32'(h1.v && h1.oor));
            if (h1.v && !h1.oor) chk("rnd_mem_addr", 32'(mem_addr), h1.a);
            if (h1.v && !h1.oor && h1.w) chk("rnd_mem_din", 32'(mem_din), 32'(h1.d));
            chk("rnd_rvalid", 32'(rvalid), (h2.v && !h2.w) ? (1 << h2.p) : 0);
            chk("rnd_rdata", 32'(rdata), (h2.v && !h2.w && !h2.oor) ? 32'(h2.d) : 32'h0);

            cur = '{0, 0, 0, 0, 24'h0, 0};
            if (pick >= 0) begin
               cur.v   = 1;
               cur.p   = pick;
               cur.w   = rw[pick];
               cur.a   = ra[pick];
               cur.oor = (ra[pick] >= DEPTH);
               cur.d   = rw[pick] ? rd[pick] : (cur.oor ? 24'h0 : model_read(ra[pick]));
               if (cur.w && !cur.oor) shadow[cur.a] = cur.d;
               if (pick == 1) m_rr = 2;
               if (pick == 2) m_rr = 1;
            end
            for (int k = 1; k < 3; k++) begin
               if (act[k] && pick != k) m_wait[k] = (m_wait[k] >= LIMIT) ? LIMIT : m_wait[k] + 1;
               else m_wait[k] = 0;
            end
            h2 = h1;
            h1 = cur;
            last_pick = pick;
            next_cycle();
         end
         req = '0;
         repeat (3) next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
